multi_timer_control: RTL and testbench

- Parametrised successor to the single-channel egg-timer controller. It runs NCH independent timer-channel state machines, each with its own set/load/run/pause/done/alarm sequencing.
- One shared button set (cook-time, start, pause, clear, sec/min increment) is routed to the channel picked by sel. Outputs drive NCH external setting counters, NCH main down-counters and per-channel LEDs/alarm.
- Adds pause/resume, clear, auto-reload and a self-silencing alarm.

---
 rtl/multi_timer_control.sv | 159 +++++++++++++++
 tb/tb_multi_timer_control.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer_control.sv
// Multi-channel egg-timer controller. NCH independent channel state machines
// share one button set routed by sel. There is one shared blink flash register,
// and each channel has its own self-silencing alarm counter.
module multi_timer_control #(
  parameter int NCH           = 4,
  parameter int SEL_W         = 2,
  parameter int ALARM_TOGGLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             cooktime_req,
  input  logic             start_timer,
  input  logic             pause_req,
  input  logic             clear_req,
  input  logic             seconds_req,
  input  logic             minutes_req,
  input  logic             blink_pulse,
  input  logic [NCH-1:0]   timer_en,
  input  logic [NCH-1:0]   timer_done,
  input  logic [NCH-1:0]   auto_reload,
  output logic [NCH-1:0]   increment_seconds,
  output logic [NCH-1:0]   increment_minutes,
  output logic [NCH-1:0]   prog_mode,
  output logic [NCH-1:0]   main_timer_enable,
  output logic [NCH-1:0]   load_timer,
  output logic [NCH-1:0]   timer_enabled_led,
  output logic [NCH-1:0]   timer_on_led,
  output logic [NCH-1:0]   alarm,
  output logic             any_alarm
);

  localparam int               CNT_W      = $clog2(ALARM_TOGGLES + 1);
  localparam logic [CNT_W-1:0] ALARM_INIT = CNT_W'(ALARM_TOGGLES);

  typedef enum logic [2:0] {IDLE, PROG, LOAD, RUN, PAUSE, DONE} state_t;

  state_t           state_q     [NCH];
  state_t           state_d     [NCH];
  logic [CNT_W-1:0] alarm_cnt_q [NCH];
  logic [CNT_W-1:0] alarm_cnt_d [NCH];
  logic             flash_q;

  logic [NCH-1:0] addressed;
  logic [NCH-1:0] cmd_clear;
  logic [NCH-1:0] cmd_cook;
  logic [NCH-1:0] cmd_start;
  logic [NCH-1:0] cmd_pause;

  // Route the shared buttons to the channel picked by sel. An out-of-range sel matches nothing.
  // NOTE: every always_comb output gets a value on every path (defaults or full
  // assignment first), otherwise synthesis infers a latch.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      addressed[i] = (int'(sel) == i);
    end
    cmd_clear = addressed & {NCH{clear_req}};
    cmd_cook  = addressed & {NCH{cooktime_req}};
    cmd_start = addressed & {NCH{start_timer}};
    cmd_pause = addressed & {NCH{pause_req}};
  end

  // Shared flash register; it toggles once per blink_pulse.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) is reserved for combinational logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_q <= 1'b0;
    end else if (blink_pulse) begin
      flash_q <= ~flash_q;
    end
  end

  // Per-channel next state. Command priority is clear > cooktime > start > pause.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          if (cmd_clear[i])      state_d[i] = IDLE;
          else if (cmd_cook[i])  state_d[i] = PROG;
          else if (cmd_start[i]) state_d[i] = LOAD;
        end
        PROG: begin
          if (cmd_clear[i])      state_d[i] = IDLE;
          else if (cmd_start[i]) state_d[i] = LOAD;
        end
        LOAD: state_d[i] = RUN;
        RUN: begin
          if (cmd_clear[i])      state_d[i] = IDLE;
          else if (cmd_cook[i])  state_d[i] = PROG;
          else if (timer_done[i]) state_d[i] = DONE;
          else if (cmd_pause[i]) state_d[i] = PAUSE;
        end
        PAUSE: begin
          if (cmd_clear[i])                     state_d[i] = IDLE;
          else if (cmd_cook[i])                 state_d[i] = PROG;
          else if (cmd_start[i] | cmd_pause[i]) state_d[i] = RUN;
        end
        DONE: begin
          if (cmd_clear[i])       state_d[i] = IDLE;
          else if (cmd_cook[i])   state_d[i] = PROG;
          else if (cmd_start[i])  state_d[i] = LOAD;
          else if (auto_reload[i]) state_d[i] = LOAD;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Alarm counters: arm on finish, count down on blink, silence on user action.
  // A channel that has just finished always arms its alarm.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      alarm_cnt_d[i] = alarm_cnt_q[i];
      if ((state_q[i] == RUN) && (state_d[i] == DONE)) begin
        alarm_cnt_d[i] = ALARM_INIT;
      end else if (cmd_clear[i] | cmd_cook[i] | cmd_start[i]) begin
        alarm_cnt_d[i] = '0;
      end else if (blink_pulse && (alarm_cnt_q[i] != '0)) begin
        alarm_cnt_d[i] = alarm_cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Channel state and alarm counter registers.
  // NOTE: these per-channel arrays are control state, not storage, so every
  // element is reset explicitly. Do not copy this into a RAM-style array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]     <= IDLE;
        alarm_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]     <= state_d[i];
        alarm_cnt_q[i] <= alarm_cnt_d[i];
      end
    end
  end

  // Output decode from channel state, the flash register and the alarm counters.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      prog_mode[i]         = (state_q[i] == PROG);
      load_timer[i]        = (state_q[i] == LOAD);
      main_timer_enable[i] = (state_q[i] == RUN) & timer_en[i];
      timer_enabled_led[i] = (state_q[i] == RUN) & timer_en[i];
      timer_on_led[i]      = (state_q[i] == RUN) & timer_en[i] & flash_q;
      increment_seconds[i] = (state_q[i] == PROG) & addressed[i] & seconds_req;
      increment_minutes[i] = (state_q[i] == PROG) & addressed[i] & minutes_req;
      alarm[i]             = (alarm_cnt_q[i] != '0) & flash_q;
    end
  end

  assign any_alarm = |alarm;

endmodule

// File: tb/tb_multi_timer_control.sv
// Directed testbench for multi_timer_control (NCH=4, SEL_W=3, ALARM_TOGGLES=10).
module tb_multi_timer_control;

  localparam int NCH   = 4;
  localparam int SEL_W = 3;

  logic             clk;
  logic             reset;
  logic [SEL_W-1:0] sel;
  logic             cooktime_req, start_timer, pause_req, clear_req;
  logic             seconds_req, minutes_req, blink_pulse;
  logic [NCH-1:0]   timer_en, timer_done, auto_reload;
  logic [NCH-1:0]   increment_seconds, increment_minutes, prog_mode;
  logic [NCH-1:0]   main_timer_enable, load_timer, timer_enabled_led;
  logic [NCH-1:0]   timer_on_led, alarm;
  logic             any_alarm;

  logic [32:0] all_out;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_flash = 1'b0;
  int          sec0_pulses = 0;
  int          sec_other_pulses = 0;

  assign all_out = {increment_seconds, increment_minutes, prog_mode, main_timer_enable,
                    load_timer, timer_enabled_led, timer_on_led, alarm, any_alarm};

  multi_timer_control #(.NCH(NCH), .SEL_W(SEL_W), .ALARM_TOGGLES(10)) dut (
    .clk(clk), .reset(reset), .sel(sel),
    .cooktime_req(cooktime_req), .start_timer(start_timer), .pause_req(pause_req),
    .clear_req(clear_req), .seconds_req(seconds_req), .minutes_req(minutes_req),
    .blink_pulse(blink_pulse), .timer_en(timer_en), .timer_done(timer_done),
    .auto_reload(auto_reload), .increment_seconds(increment_seconds),
    .increment_minutes(increment_minutes), .prog_mode(prog_mode),
    .main_timer_enable(main_timer_enable), .load_timer(load_timer),
    .timer_enabled_led(timer_enabled_led), .timer_on_led(timer_on_led),
    .alarm(alarm), .any_alarm(any_alarm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count increment strobes as the setting counters would see them.
  always @(posedge clk) begin
    if (increment_seconds[0]) sec0_pulses++;
    if (|increment_seconds[3:1]) sec_other_pulses++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic blink();
    blink_pulse = 1'b1;
    step();
    blink_pulse = 1'b0;
    exp_flash = ~exp_flash;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    n_cmp++;
    if (all_out !== 33'd0) begin n_err++; $display("FAIL reset_hold: got %h expected %h", all_out, 33'd0); end
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (all_out !== 33'd0) begin n_err++; $display("FAIL reset_release: got %h expected %h", all_out, 33'd0); end
  endtask

  task automatic test_program();
    sel = 3'd0; cooktime_req = 1'b1;
    step();
    cooktime_req = 1'b0;
    n_cmp++;
    if (prog_mode !== 4'b0001) begin n_err++; $display("FAIL prog_enter: got %b expected %b", prog_mode, 4'b0001); end
    for (int k = 0; k < 3; k++) begin
      seconds_req = 1'b1;
      #1;
      n_cmp++;
      if (increment_seconds !== 4'b0001) begin n_err++; $display("FAIL inc_sec_high: got %b expected %b", increment_seconds, 4'b0001); end
      step();
      seconds_req = 1'b0;
      #1;
      n_cmp++;
      if (increment_seconds !== 4'b0000) begin n_err++; $display("FAIL inc_sec_low: got %b expected %b", increment_seconds, 4'b0000); end
    end
    minutes_req = 1'b1;
    #1;
    n_cmp++;
    if (increment_minutes !== 4'b0001) begin n_err++; $display("FAIL inc_min: got %b expected %b", increment_minutes, 4'b0001); end
    step();
    minutes_req = 1'b0;
    // Moving sel away leaves ch0 in PROG, but ch0 no longer receives increments.
    sel = 3'd1; seconds_req = 1'b1;
    #1;
    n_cmp++;
    if (increment_seconds !== 4'b0000) begin n_err++; $display("FAIL sel_moved_inc: got %b expected %b", increment_seconds, 4'b0000); end
    n_cmp++;
    if (prog_mode !== 4'b0001) begin n_err++; $display("FAIL sel_moved_prog: got %b expected %b", prog_mode, 4'b0001); end
    step();
    seconds_req = 1'b0; sel = 3'd0;
    n_cmp++;
    if (sec0_pulses !== 3) begin n_err++; $display("FAIL sec0_count: got %0d expected %0d", sec0_pulses, 3); end
    n_cmp++;
    if (sec_other_pulses !== 0) begin n_err++; $display("FAIL sec_other_count: got %0d expected %0d", sec_other_pulses, 0); end
  endtask

  task automatic test_run_alarm();
    logic exp_alarm;
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    n_cmp++;
    if ({load_timer, prog_mode} !== 8'b0001_0000) begin n_err++; $display("FAIL load_pulse: got %b expected %b", {load_timer, prog_mode}, 8'b0001_0000); end
    step();
    n_cmp++;
    if ({load_timer, main_timer_enable, timer_enabled_led} !== 12'b0000_0001_0001) begin
      n_err++; $display("FAIL run_enter: got %b expected %b", {load_timer, main_timer_enable, timer_enabled_led}, 12'b0000_0001_0001);
    end
    blink();
    n_cmp++;
    if (timer_on_led !== 4'b0001) begin n_err++; $display("FAIL on_led_lit: got %b expected %b", timer_on_led, 4'b0001); end
    blink();
    n_cmp++;
    if (timer_on_led !== 4'b0000) begin n_err++; $display("FAIL on_led_dark: got %b expected %b", timer_on_led, 4'b0000); end
    // Finish with flash low, so odd-numbered blinks show the alarm.
    timer_done = 4'b0001;
    step();
    timer_done = 4'b0000;
    n_cmp++;
    if (main_timer_enable !== 4'b0000) begin n_err++; $display("FAIL done_enter: got %b expected %b", main_timer_enable, 4'b0000); end
    for (int k = 1; k <= 11; k++) begin
      blink();
      exp_alarm = (k < 10) ? exp_flash : 1'b0;
      n_cmp++;
      if ({alarm, any_alarm} !== {3'b000, exp_alarm, exp_alarm}) begin
        n_err++; $display("FAIL alarm_blink%0d: got %b expected %b", k, {alarm, any_alarm}, {3'b000, exp_alarm, exp_alarm});
      end
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
  endtask

  task automatic test_pause();
    sel = 3'd1; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    step();
    n_cmp++;
    if (main_timer_enable !== 4'b0010) begin n_err++; $display("FAIL ch1_run: got %b expected %b", main_timer_enable, 4'b0010); end
    pause_req = 1'b1;
    step();
    pause_req = 1'b0;
    n_cmp++;
    if ({main_timer_enable, load_timer} !== 8'b0) begin n_err++; $display("FAIL ch1_pause: got %b expected %b", {main_timer_enable, load_timer}, 8'b0); end
    timer_done = 4'b0010;
    step();
    timer_done = 4'b0000;
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    n_cmp++;
    if ({main_timer_enable, load_timer} !== 8'b0010_0000) begin
      n_err++; $display("FAIL ch1_resume: got %b expected %b", {main_timer_enable, load_timer}, 8'b0010_0000);
    end
    pause_req = 1'b1; timer_done = 4'b0010;
    step();
    pause_req = 1'b0; timer_done = 4'b0000;
    if (!exp_flash) blink();
    n_cmp++;
    if ({main_timer_enable, alarm} !== 8'b0000_0010) begin
      n_err++; $display("FAIL done_beats_pause: got %b expected %b", {main_timer_enable, alarm}, 8'b0000_0010);
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n_cmp++;
    if (alarm !== 4'b0000) begin n_err++; $display("FAIL ch1_clear_alarm: got %b expected %b", alarm, 4'b0000); end
  endtask

  task automatic test_auto_reload();
    auto_reload = 4'b0100; sel = 3'd2; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    step();
    timer_done = 4'b0100;
    step();
    timer_done = 4'b0000;
    n_cmp++;
    if ({main_timer_enable, load_timer} !== 8'b0) begin n_err++; $display("FAIL ar_done: got %b expected %b", {main_timer_enable, load_timer}, 8'b0); end
    step();
    n_cmp++;
    if (load_timer !== 4'b0100) begin n_err++; $display("FAIL ar_load: got %b expected %b", load_timer, 4'b0100); end
    step();
    n_cmp++;
    if ({main_timer_enable, load_timer} !== 8'b0100_0000) begin
      n_err++; $display("FAIL ar_run: got %b expected %b", {main_timer_enable, load_timer}, 8'b0100_0000);
    end
    if (!exp_flash) blink();
    n_cmp++;
    if (alarm !== 4'b0100) begin n_err++; $display("FAIL ar_alarm_kept: got %b expected %b", alarm, 4'b0100); end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n_cmp++;
    if ({main_timer_enable, alarm} !== 8'b0) begin n_err++; $display("FAIL ar_clear: got %b expected %b", {main_timer_enable, alarm}, 8'b0); end
    auto_reload = 4'b0000;
  endtask

  task automatic test_isolation();
    sel = 3'd0; start_timer = 1'b1;
    step();
    sel = 3'd3;
    step();
    start_timer = 1'b0;
    step();
    n_cmp++;
    if (main_timer_enable !== 4'b1001) begin n_err++; $display("FAIL both_run: got %b expected %b", main_timer_enable, 4'b1001); end
    clear_req = 1'b1; start_timer = 1'b1;
    step();
    clear_req = 1'b0; start_timer = 1'b0;
    n_cmp++;
    if ({main_timer_enable, load_timer} !== 8'b0001_0000) begin
      n_err++; $display("FAIL clear_over_start: got %b expected %b", {main_timer_enable, load_timer}, 8'b0001_0000);
    end
    sel = 3'b111; clear_req = 1'b1; cooktime_req = 1'b1; start_timer = 1'b1; pause_req = 1'b1; seconds_req = 1'b1;
    step();
    clear_req = 1'b0; cooktime_req = 1'b0; start_timer = 1'b0; pause_req = 1'b0; seconds_req = 1'b0;
    n_cmp++;
    if ({main_timer_enable, prog_mode, load_timer} !== 12'b0001_0000_0000) begin
      n_err++; $display("FAIL sel_out_of_range: got %b expected %b", {main_timer_enable, prog_mode, load_timer}, 12'b0001_0000_0000);
    end
    sel = 3'd4; cooktime_req = 1'b1;
    step();
    cooktime_req = 1'b0;
    n_cmp++;
    if (prog_mode !== 4'b0000) begin n_err++; $display("FAIL sel4_cook: got %b expected %b", prog_mode, 4'b0000); end
    timer_en = 4'b1110;
    #1;
    n_cmp++;
    if ({main_timer_enable, timer_enabled_led} !== 8'b0) begin
      n_err++; $display("FAIL timer_en_gate: got %b expected %b", {main_timer_enable, timer_enabled_led}, 8'b0);
    end
    timer_en = 4'b1111;
  endtask

  task automatic test_reset_midflight();
    sel = 3'd1; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    step();
    timer_done = 4'b0010;
    step();
    timer_done = 4'b0000;
    if (!exp_flash) blink();
    n_cmp++;
    if (alarm !== 4'b0010) begin n_err++; $display("FAIL pre_reset_alarm: got %b expected %b", alarm, 4'b0010); end
    sel = 3'd0; cooktime_req = 1'b1;
    step();
    cooktime_req = 1'b0; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    n_cmp++;
    if (load_timer !== 4'b0001) begin n_err++; $display("FAIL pre_reset_load: got %b expected %b", load_timer, 4'b0001); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (all_out !== 33'd0) begin n_err++; $display("FAIL async_reset: got %h expected %h", all_out, 33'd0); end
    exp_flash = 1'b0;
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (all_out !== 33'd0) begin n_err++; $display("FAIL post_reset: got %h expected %h", all_out, 33'd0); end
    blink();
    n_cmp++;
    if ({alarm, any_alarm, timer_on_led} !== 9'b0) begin
      n_err++; $display("FAIL alarm_cleared: got %b expected %b", {alarm, any_alarm, timer_on_led}, 9'b0);
    end
  endtask

  initial begin
    reset = 1'b0; sel = '0;
    cooktime_req = 1'b0; start_timer = 1'b0; pause_req = 1'b0; clear_req = 1'b0;
    seconds_req = 1'b0; minutes_req = 1'b0; blink_pulse = 1'b0;
    timer_en = 4'b1111; timer_done = 4'b0000; auto_reload = 4'b0000;
    test_reset();
    test_program();
    test_run_alarm();
    test_pause();
    test_auto_reload();
    test_isolation();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
